sr_run_ctrl: RTL and testbench
==============================

Name: sr_run_ctrl

Overview:
Run/halt/step controller for the single-cycle RISC-V core. It generates the core's clock-enable (cpuEn) and sequences execution from a host command port: free-run, halt, N-instruction step, and a single hardware PC breakpoint. Because the core retires exactly one instruction per enabled cycle, the block also keeps cycle and retired-instruction counters. It sits between the debug host (UART/JTAG bridge) and the core's pc register and register-file write enables.

Parameters:
CNT_W, 32, width of cycCnt and instrCnt
STEP_W, 16, width of the step counter, taken from cmdArg[STEP_W-1:0]

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmdValid  in  1  host command valid
cmdReady  out  1  command accepted when cmdValid && cmdReady
cmdCode  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SETBP, 5 CLRBP, 6 CLRCNT, 7 reserved (NOP)
cmdArg  in  32  step count (STEP) or breakpoint byte address (SETBP)
pc  in  32  current core PC (byte address)
cpuEn  out  1  core clock-enable; gates the pc register and the register-file write
state  out  2  0 HALT, 1 RUN, 2 STEP, 3 BRK
bpHit  out  1  one-cycle pulse on entry to BRK
stepDone  out  1  one-cycle pulse when a STEP completes
cycCnt  out  CNT_W  clocks since reset or CLRCNT
instrCnt  out  CNT_W  cycles with cpuEn=1 since reset or CLRCNT

Behaviour:
- Reset (rst=1 at a clk edge): state=HALT, cpuEn=0, bpHit=0, stepDone=0, cycCnt=0, instrCnt=0, bpEn=0, bpAddr=0, skipBp=0, stepCnt=0. cmdReady=1 after reset.
- cmdReady is 0 in STEP and 1 in all other states. A command is accepted at the edge where cmdValid && cmdReady. Its effect is visible from the next cycle, so command-to-cpuEn latency is 1 cycle.
- cpuEn is combinational:
  - In RUN: cpuEn = !(bpEn && pc==bpAddr && !skipBp).
  - In STEP: cpuEn = 1.
  - In HALT and BRK: cpuEn = 0.
- HALT (cmd 1): accepted in RUN, HALT and BRK. Next state is HALT.
- RUN (cmd 2): from HALT or BRK goes to RUN and sets skipBp=1, so the instruction at the breakpoint address executes once on resume. skipBp clears after the first cycle with cpuEn=1. RUN while already in RUN is a no-op and does not set skipBp.
- Breakpoint: in RUN, if the match is true and skipBp=0, then cpuEn=0 in that cycle and the next state is BRK. bpHit pulses for the first cycle in BRK. The core holds with pc==bpAddr, and the instruction at bpAddr has not executed.
- STEP (cmd 3): from HALT or BRK. n = cmdArg[STEP_W-1:0], and n=0 is treated as 1. stepCnt loads n-1.
  - Each STEP cycle either decrements stepCnt or, when stepCnt==0, sets next state to HALT and asserts stepDone in the first HALT cycle.
  - cpuEn is therefore high for exactly n consecutive cycles. Breakpoints are ignored in STEP.
  - STEP while in RUN is a no-op (accepted, ignored).
- SETBP (cmd 4): bpAddr = {cmdArg[31:2],2'b00}, bpEn=1, accepted in any ready state. CLRBP (cmd 5): bpEn=0.
- Both set and clear take effect from the next cycle. A SETBP accepted in RUN may therefore stop the core on the following cycle.
- CLRCNT (cmd 6):
  - cycCnt is 0 in the next cycle.
  - instrCnt is 0 in the next cycle, or 1 if cpuEn was 1 in the accepting cycle (clear has priority, then the retire increment is applied).
  - State is unchanged.
- Counters: cycCnt increments every non-reset cycle. instrCnt increments when cpuEn=1. Both wrap modulo 2^CNT_W with no saturation or flag.
- Simultaneous events:
  - A breakpoint match and a HALT accepted in the same cycle give HALT (host command wins), bpHit=0, cpuEn=0 that cycle.
  - rst has priority over everything, including mid-STEP: it aborts the step with no stepDone.
- Reserved and NOP codes are accepted with no effect.

Test Plan:
- Reset then idle 5 cycles -> state=0, cpuEn=0, cycCnt=5, instrCnt=0, cmdReady=1.
- STEP n=3 from HALT -> cmdReady=0 for 3 cycles, cpuEn=1 for exactly 3 cycles, state returns to 0, stepDone pulses once, instrCnt=3. Repeat with n=0 -> exactly 1 enabled cycle.
- SETBP 0x0000_0010, RUN with the core counting pc 0,4,8,... -> cpuEn falls in the cycle pc==0x10, state=3, bpHit pulse, instrCnt=4. RUN again -> the 0x10 instruction executes, pc reaches 0x14 with no re-break. Wrap pc to 0x10 -> breaks again.
- In RUN, assert cmdValid with STEP -> accepted, no state change. Then HALT -> cpuEn=0 from the next cycle. Then CLRBP and RUN -> no break at 0x10.
- Breakpoint match and HALT command in the same cycle -> state=HALT, bpHit=0. Separately, rst asserted at step 2 of STEP n=5 -> all outputs at reset values, stepDone never pulses.
- CNT_W=4: run 17 cycles -> cycCnt=1 (wrapped). CLRCNT while cpuEn=1 -> cycCnt=0 and instrCnt=1 next cycle.

Source files
------------

// File: rtl/sr_run_ctrl.sv
// sr_run_ctrl: run/halt/step/breakpoint controller producing the core clock-enable,
// plus cycle and retired-instruction counters.
module sr_run_ctrl #(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [2:0]       cmdCode,
    input  logic [31:0]      cmdArg,
    input  logic [31:0]      pc,
    output logic             cpuEn,
    output logic [1:0]       state,
    output logic             bpHit,
    output logic             stepDone,
    output logic [CNT_W-1:0] cycCnt,
    output logic [CNT_W-1:0] instrCnt
);
    typedef enum logic [1:0] {HALT, RUN, STEP, BRK} state_t;
    localparam logic [2:0] C_HALT = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3;
    localparam logic [2:0] C_SETBP = 3'd4, C_CLRBP = 3'd5, C_CLRCNT = 3'd6;

    state_t cur, nxt;
    logic bp_en, skip_bp, accept, bp_match, idle, clr;
    logic [31:0] bp_addr;
    logic [STEP_W-1:0] step_cnt, step_n;

    assign state    = cur;
    assign accept   = cmdValid && cmdReady;
    assign idle     = cur == HALT || cur == BRK;
    assign clr      = accept && cmdCode == C_CLRCNT;
    assign step_n   = cmdArg[STEP_W-1:0];
    assign bp_match = bp_en && pc == bp_addr && !skip_bp;

    always_ff @(posedge clk)
        cur <= rst ? HALT : nxt;

    always_comb begin
        nxt = cur;
        if (cur == RUN)
            nxt = (accept && cmdCode == C_HALT) ? HALT : bp_match ? BRK : RUN;
        else if (cur == STEP)
            nxt = step_cnt == '0 ? HALT : STEP;
        else if (accept)
            nxt = cmdCode == C_HALT ? HALT : cmdCode == C_RUN ? RUN :
                  cmdCode == C_STEP ? STEP : cur;
    end

    always_comb begin
        cmdReady = cur != STEP;
        cpuEn    = cur == RUN ? !bp_match : cur == STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bpHit    <= 1'b0;
            stepDone <= 1'b0;
            cycCnt   <= '0;
            instrCnt <= '0;
            bp_en    <= 1'b0;
            bp_addr  <= '0;
            skip_bp  <= 1'b0;
            step_cnt <= '0;
        end else begin
            bpHit    <= cur == RUN && nxt == BRK;
            stepDone <= cur == STEP && nxt == HALT;
            cycCnt   <= clr ? '0 : cycCnt + 1'b1;
            // clear wins, then the retire in the accepting cycle still counts
            instrCnt <= (clr ? '0 : instrCnt) + CNT_W'(cpuEn);
            if (accept && idle && cmdCode == C_RUN)
                skip_bp <= 1'b1;
            else if (cpuEn)
                skip_bp <= 1'b0;
            if (accept && idle && cmdCode == C_STEP)
                step_cnt <= step_n == '0 ? '0 : step_n - 1'b1;
            else if (cur == STEP && step_cnt != '0)
                step_cnt <= step_cnt - 1'b1;
            if (accept && cmdCode == C_SETBP) begin
                bp_en   <= 1'b1;
                bp_addr <= {cmdArg[31:2], 2'b00};
            end else if (accept && cmdCode == C_CLRBP) begin
                bp_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sr_run_ctrl.sv
// tb_sr_run_ctrl: directed scenarios plus random commands, checked every cycle
// against a behavioural model of the run controller.
module tb_sr_run_ctrl;
    logic clk = 0, rst = 1, cmdValid = 0, pc_jump = 0;
    logic [2:0] cmdCode = 0;
    logic [31:0] cmdArg = 0, pc = 0, jump_addr = 0;
    logic cmdReady, cpuEn, bpHit, stepDone;
    logic [1:0] state;
    logic [31:0] cycCnt, instrCnt;
    logic s_ready, s_en, s_hit, s_done;
    logic [1:0] s_state;
    logic [3:0] s_cyc, s_ins;
    int n_cmp = 0, n_bad = 0;

    int m_state, m_left;
    bit m_valid = 0, m_bp_en, m_skip, m_hit, m_done;
    logic [31:0] m_bp, m_cyc, m_ins;

    sr_run_ctrl u_dut (.clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdCode(cmdCode), .cmdArg(cmdArg), .pc(pc), .cpuEn(cpuEn), .state(state),
        .bpHit(bpHit), .stepDone(stepDone), .cycCnt(cycCnt), .instrCnt(instrCnt));

    sr_run_ctrl #(.CNT_W(4)) u_small (.clk(clk), .rst(rst), .cmdValid(cmdValid),
        .cmdReady(s_ready), .cmdCode(cmdCode), .cmdArg(cmdArg), .pc(pc), .cpuEn(s_en),
        .state(s_state), .bpHit(s_hit), .stepDone(s_done), .cycCnt(s_cyc), .instrCnt(s_ins));

    always #5 clk = ~clk;

    // the core: pc advances one word per enabled cycle unless the bench forces a jump
    always @(posedge clk) pc <= pc_jump ? jump_addr : cpuEn ? pc + 32'd4 : pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit en, rdy, acc, match;
        forever begin
            @(negedge clk);
            match = m_bp_en && pc == m_bp && !m_skip;
            en = m_state == 1 ? !match : m_state == 2;
            rdy = m_state != 2;
            if (m_valid) begin
                check("cpuEn", cpuEn, en);
                check("cmdReady", cmdReady, rdy);
                check("state", state, m_state);
                check("bpHit", bpHit, m_hit);
                check("stepDone", stepDone, m_done);
                check("cycCnt", cycCnt, m_cyc);
                check("instrCnt", instrCnt, m_ins);
                check("small_state", s_state, m_state);
                check("small_cyc", s_cyc, m_cyc & 32'hf);
                check("small_ins", s_ins, m_ins & 32'hf);
            end
            acc = cmdValid && rdy;
            if (rst) begin
                m_valid = 1; m_state = 0; m_left = 0; m_bp_en = 0; m_skip = 0;
                m_hit = 0; m_done = 0; m_bp = 0; m_cyc = 0; m_ins = 0;
            end else begin
                m_hit = 0;
                m_done = 0;
                m_cyc = (acc && cmdCode == 6) ? 0 : m_cyc + 1;
                m_ins = ((acc && cmdCode == 6) ? 32'd0 : m_ins) + 32'(en);
                if (en) m_skip = 0;
                if (m_state == 0 || m_state == 3) begin
                    if (acc && cmdCode == 2) begin m_state = 1; m_skip = 1; end
                    else if (acc && cmdCode == 3) begin
                        m_state = 2;
                        m_left = cmdArg[15:0] == 0 ? 1 : int'(cmdArg[15:0]);
                    end else if (acc && cmdCode == 1) m_state = 0;
                end else if (m_state == 1) begin
                    if (acc && cmdCode == 1) m_state = 0;
                    else if (match) begin m_state = 3; m_hit = 1; end
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_state = 0; m_done = 1; end
                end
                if (acc && cmdCode == 4) begin m_bp_en = 1; m_bp = cmdArg & ~32'd3; end
                else if (acc && cmdCode == 5) m_bp_en = 0;
            end
        end
    end

    task automatic tick; @(posedge clk); #1; endtask

    task automatic cmd(input logic [2:0] c, input logic [31:0] a);
        cmdValid = 1; cmdCode = c; cmdArg = a;
        tick;
        cmdValid = 0; cmdCode = 0; cmdArg = 0;
    endtask

    task automatic jump(input logic [31:0] a);
        pc_jump = 1; jump_addr = a;
        tick;
        pc_jump = 0;
    endtask

    task automatic wait_state(input logic [1:0] s);
        for (int i = 0; i < 60 && state != s; i++) tick;
        check("wait_state", state, s);
    endtask

    task automatic step_run(input logic [31:0] n, input int exp_en);
        int en_c = 0, busy_c = 0, done_c = 0;
        cmd(3'd3, n);
        for (int i = 0; i < 10; i++) begin
            en_c += int'(cpuEn);
            busy_c += int'(!cmdReady);
            done_c += int'(stepDone);
            tick;
        end
        check("step_en_cycles", en_c, exp_en);
        check("step_busy_cycles", busy_c, exp_en);
        check("step_done_pulses", done_c, 1);
        check("step_end_state", state, 0);
    endtask

    initial begin
        int brk_c, done_c;
        tick; tick;
        rst = 0;
        repeat (5) tick;
        check("idle_cyc", cycCnt, 5);
        check("idle_ins", instrCnt, 0);
        check("idle_state", state, 0);
        check("idle_en", cpuEn, 0);
        check("idle_ready", cmdReady, 1);

        step_run(32'd3, 3);
        check("step3_ins", instrCnt, 3);
        step_run(32'hABCD_0000, 1);
        check("step0_ins", instrCnt, 4);

        jump(0);
        cmd(3'd6, 0);
        check("clr_ins_halted", instrCnt, 0);
        cmd(3'd4, 32'h10);
        cmd(3'd2, 0);
        wait_state(3);
        check("brk_hit", bpHit, 1);
        check("brk_pc", pc, 32'h10);
        check("brk_ins", instrCnt, 4);
        check("brk_en", cpuEn, 0);
        tick;
        check("brk_hit_once", bpHit, 0);
        cmd(3'd2, 0);
        tick;
        check("resume_pc", pc, 32'h14);
        check("resume_state", state, 1);
        jump(32'h10);
        wait_state(3);
        check("rebrk_pc", pc, 32'h10);

        cmd(3'd2, 0);
        cmd(3'd3, 32'd5);
        check("step_in_run_state", state, 1);
        cmd(3'd1, 0);
        check("halt_en", cpuEn, 0);
        check("halt_state", state, 0);
        cmd(3'd5, 0);
        jump(0);
        cmd(3'd2, 0);
        brk_c = 0;
        repeat (10) begin tick; brk_c += int'(state == 3); end
        check("clrbp_no_break", brk_c, 0);

        cmd(3'd1, 0);
        jump(0);
        cmd(3'd4, 32'h13);
        cmd(3'd2, 0);
        for (int i = 0; i < 20 && pc != 32'h10; i++) tick;
        check("race_pc", pc, 32'h10);
        cmd(3'd1, 0);
        check("race_state", state, 0);
        check("race_hit", bpHit, 0);

        cmd(3'd3, 32'd5);
        tick;
        rst = 1; tick; rst = 0;
        check("rst_state", state, 0);
        check("rst_en", cpuEn, 0);
        check("rst_cyc", cycCnt, 0);
        check("rst_ins", instrCnt, 0);
        check("rst_ready", cmdReady, 1);
        done_c = 0;
        repeat (8) begin done_c += int'(stepDone); tick; end
        check("rst_no_done", done_c, 0);

        rst = 1; tick; rst = 0;
        repeat (17) tick;
        check("wrap_small_cyc", s_cyc, 1);
        check("wrap_big_cyc", cycCnt, 17);
        cmd(3'd2, 0);
        cmd(3'd6, 0);
        check("clr_cyc", cycCnt, 0);
        check("clr_ins", instrCnt, 1);
        check("clr_small_ins", s_ins, 1);
        check("clr_state", state, 1);

        repeat (800) begin
            rst = $urandom_range(0, 149) == 0;
            pc_jump = $urandom_range(0, 9) == 0;
            jump_addr = 4 * $urandom_range(0, 12);
            cmdValid = $urandom_range(0, 2) == 0;
            cmdCode = 3'($urandom_range(0, 7));
            cmdArg = cmdCode == 3'd4 ? $urandom_range(0, 50)
                                     : ($urandom & 32'hFFFF_0000) | $urandom_range(0, 5);
            tick;
        end
        rst = 0; pc_jump = 0; cmdValid = 0;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
